axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester arbiter for the core's single AXI4 read port. The instruction fetch unit (IF) and the load unit (LS) share the AR and R channels through it. It runs one outstanding single-beat read at a time, arbitrates round-robin, holds the AR channel stable until the handshake completes, and routes the R beat back to whichever requester owns it. It sits between the pipeline front/back ends and the top-level AXI master port.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, RDATA width
- ID_IF, 4'd0, ARID used for IF reads
- ID_LS, 4'd1, ARID used for LS reads

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset; **asynchronous, active-low**
- if_req  in  1  IF read request; held until if_gnt
- if_addr  in  ADDR_W  IF address; stable while if_req
- if_gnt  out  1  pulse: IF address accepted on AR
- if_rvalid  out  1  pulse: IF data returned
- if_rdata  out  DATA_W  IF read data (=RDATA)
- if_rresp  out  2  IF response code (=RRESP)
- ls_req, ls_addr, ls_size[2:0], ls_gnt, ls_rvalid, ls_rdata, ls_rresp  same as IF; ls_size drives ARSIZE
- ARID  out  4;  ARADDR  out  ADDR_W;  ARLEN  out  8;  ARSIZE  out  3;  ARBURST  out  2;  ARPROT  out  3;  ARVALID  out  1;  ARREADY  in  1
- RID  in  4;  RDATA  in  DATA_W;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1

## Operation
- State machine: IDLE, ADDR, DATA.
- **IDLE**
  - If any request is pending, pick a winner, register its ID, address and size into the AR registers, set ARVALID=1, and go to ADDR.
- **Arbitration**
  - Only one request pending: it wins.
  - Both pending: the requester not granted last wins.
  - last_gnt resets to LS, so IF wins the first tie.
- **ADDR**
  - AR outputs are frozen while ARVALID=1 and ARREADY=0.
  - On ARREADY: ARVALID←0, pulse the winner's gnt for that same cycle, go to DATA.
- **DATA**
  - RREADY=1.
  - A beat with RVALID=1 and RID equal to the registered ID is forwarded: assert the winner's rvalid with RDATA/RRESP, combinationally in the same cycle.
  - If that beat also has RLAST=1: update last_gnt and go to IDLE.
  - Beats with a mismatched RID are accepted and dropped.
- Every read has ARLEN=0, ARBURST=INCR(01), ARPROT=100 for IF and 000 for LS. IF uses ARSIZE=010; LS uses ls_size.
- SLVERR/DECERR responses are forwarded in rresp and complete the transaction normally.
- Reset values: ARVALID=0, RREADY=0, all AR fields 0, all gnt/rvalid 0, state IDLE, last_gnt=LS.

## Timing
- Request sampled in IDLE at cycle N: ARVALID=1 at N+1; earliest gnt is N+1 (if ARREADY=1).
- Earliest data: the cycle after gnt. The rvalid pulse is combinational from RVALID.
- After a completing beat, there is one IDLE cycle before the next ARVALID. Back-to-back throughput is one read per 3 cycles minimum.
- A requester must not drop req before gnt. Dropping req after ARVALID has risen does not cancel the read.
- Changing req in the same cycle as the completing R beat takes effect in the following IDLE cycle.
- Reset mid-transaction: ARVALID and RREADY fall asynchronously. Any in-flight response is lost, no rvalid is issued, and requesters must re-request.

## Structure
- Shared package:
  - state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10)
  - AXI constants (BURST_INCR, SIZE_4, RESP_OKAY, PROT_INSTR, PROT_DATA)
  - the ID constants
- Natural sub-module: rr_arb2, a two-way round-robin picker with a last-grant register updated on a done strobe.

## Test plan
- IF only, ARREADY=1 immediately, RVALID with RID=0, RDATA=0x13, RLAST=1 two cycles later → ARADDR=if_addr, ARPROT=100, if_gnt one pulse, if_rvalid with if_rdata=0x13, ls outputs quiet.
- IF and LS both requesting from reset → IF served first, then LS with ARID=1 and ARSIZE=ls_size; the next tie goes to IF again.
- ARREADY held low 5 cycles → ARVALID stays 1 and ARADDR/ARID/ARSIZE stay constant; gnt pulses only on the ARREADY cycle.
- In DATA, beat with RID=1 while IF owns the transaction, then beat with RID=0 → first beat dropped with no rvalid; second completes IF.
- LS read returns RRESP=10 → ls_rvalid=1, ls_rresp=10, FSM returns to IDLE.
- rstn asserted in DATA → ARVALID=0 and RREADY=0 immediately, no rvalid; after release, a pending request restarts at IDLE with IF winning the tie.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the IF/LS AXI read arbiter: FSM states, AXI field constants, requester IDs.
// Pure constants; no latency or flow-control behaviour of its own.
package axi_rd_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4     = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;

  localparam logic [3:0] ID_IF_DEF = 4'd0;
  localparam logic [3:0] ID_LS_DEF = 4'd1;

  // Requester index used by the round-robin picker and the ownership register.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational pick, last-grant register updated on done_i.
// Zero-latency pick; never stalls, the caller decides when a pick is consumed.
module axi_rd_arbiter_rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic       any_o,
  output logic       pick_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    pick_o = REQ_IF;
    if (req_i == 2'b11) begin
      // Tie: the requester that was not served last goes next.
      pick_o = ~last_q;
    end else if (req_i[1]) begin
      pick_o = REQ_LS;
    end
  end

  assign any_o  = |req_i;
  assign last_d = done_i ? done_idx_i : last_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= REQ_LS;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between IF and LS; one single-beat read outstanding, AR 1 cycle after request.
// AR held stable until ARREADY; R beats for the owner forwarded combinationally, foreign RIDs dropped.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 64,
  parameter int         DATA_W = 64,
  parameter logic [3:0] ID_IF  = ID_IF_DEF,
  parameter logic [3:0] ID_LS  = ID_LS_DEF
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic [1:0]        if_rresp,

  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_size,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [1:0]        ls_rresp,

  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,

  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  logic [1:0]        state_q,   state_d;
  logic              owner_q,   owner_d;
  logic              arvalid_q, arvalid_d;
  logic [3:0]        arid_q,    arid_d;
  logic [ADDR_W-1:0] araddr_q,  araddr_d;
  logic [2:0]        arsize_q,  arsize_d;
  logic [2:0]        arprot_q,  arprot_d;
  logic [1:0]        arburst_q, arburst_d;

  logic arb_any;
  logic arb_pick;
  logic ar_hs;
  logic beat_hit;
  logic rd_done;

  axi_rd_arbiter_rr_arb2 u_rr (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .req_i      ({ls_req, if_req}),
    .done_i     (rd_done),
    .done_idx_i (owner_q),
    .any_o      (arb_any),
    .pick_o     (arb_pick)
  );

  assign ar_hs    = (state_q == ST_ADDR) && ARREADY;
  assign RREADY   = (state_q == ST_DATA);
  assign beat_hit = RREADY && RVALID && (RID == arid_q);
  assign rd_done  = beat_hit && RLAST;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arprot_d  = arprot_q;
    arburst_d = arburst_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d   = ST_ADDR;
          arvalid_d = 1'b1;
          owner_d   = arb_pick;
          arburst_d = BURST_INCR;
          if (arb_pick == REQ_LS) begin
            arid_d   = ID_LS;
            araddr_d = ls_addr;
            arsize_d = ls_size;
            arprot_d = PROT_DATA;
          end else begin
            arid_d   = ID_IF;
            araddr_d = if_addr;
            arsize_d = SIZE_4;
            arprot_d = PROT_INSTR;
          end
        end
      end
      ST_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        // Error responses complete the read exactly like OKAY; only RID/RLAST matter here.
        if (rd_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_IF;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arprot_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arprot_q  <= arprot_d;
      arburst_q <= arburst_d;
    end
  end

  assign ARVALID = arvalid_q;
  assign ARID    = arid_q;
  assign ARADDR  = araddr_q;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = arsize_q;
  assign ARBURST = arburst_q;
  assign ARPROT  = arprot_q;

  assign if_gnt    = ar_hs && (owner_q == REQ_IF);
  assign ls_gnt    = ar_hs && (owner_q == REQ_LS);
  assign if_rvalid = beat_hit && (owner_q == REQ_IF);
  assign ls_rvalid = beat_hit && (owner_q == REQ_LS);
  assign if_rdata  = RDATA;
  assign ls_rdata  = RDATA;
  assign if_rresp  = RRESP;
  assign ls_rresp  = RRESP;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AR and R expectations queued at stimulus time, checked on DUT output.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, ls_req;
  logic [63:0] if_addr, ls_addr;
  logic [2:0]  ls_size;
  logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid;
  logic [63:0] if_rdata, ls_rdata;
  logic [1:0]  if_rresp, ls_rresp;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;

  typedef struct {
    logic        is_ls;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [2:0]  prot;
  } ar_exp_t;

  typedef struct {
    logic        is_ls;
    logic [63:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  ar_exp_t    ar_q[$];
  r_exp_t     r_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       cur_ls;
  logic [3:0] cur_id;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .ID_IF(ID_IF_DEF), .ID_LS(ID_LS_DEF)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_rresp(if_rresp),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_size(ls_size), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_rresp(ls_rresp),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_if(input logic [63:0] a);
    ar_q.push_back('{1'b0, ID_IF_DEF, a, SIZE_4, PROT_INSTR});
  endtask

  task automatic push_ls(input logic [63:0] a, input logic [2:0] sz);
    ar_q.push_back('{1'b1, ID_LS_DEF, a, sz, PROT_DATA});
  endtask

  // Waits for ARVALID, holds ARREADY low for 'stall' cycles, then completes the AR handshake.
  task automatic do_ar(input int stall);
    ar_exp_t e;
    int n;
    e = ar_q.pop_front();
    ARREADY = (stall == 0);
    n = 0;
    while (ARVALID !== 1'b1 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("ar_latency", n, 1);
    chk("arvalid", ARVALID, 1'b1);
    chk("araddr", ARADDR, e.addr);
    chk("arid", ARID, e.id);
    chk("arsize", ARSIZE, e.size);
    chk("arprot", ARPROT, e.prot);
    chk("arlen", ARLEN, 8'd0);
    chk("arburst", ARBURST, BURST_INCR);
    for (int i = 0; i < stall; i++) begin
      chk("gnt_stall", {if_gnt, ls_gnt}, 2'b00);
      @(negedge clk); #1;
      chk("arvalid_hold", ARVALID, 1'b1);
      chk("araddr_hold", ARADDR, e.addr);
      chk("arid_hold", ARID, e.id);
      chk("arsize_hold", ARSIZE, e.size);
    end
    ARREADY = 1'b1; #1;
    chk("if_gnt", if_gnt, !e.is_ls);
    chk("ls_gnt", ls_gnt, e.is_ls);
    cur_ls = e.is_ls;
    cur_id = e.id;
    @(negedge clk);
    ARREADY = 1'b0;
    if (e.is_ls) ls_req = 1'b0; else if_req = 1'b0;
    #1;
    chk("arvalid_fall", ARVALID, 1'b0);
    chk("rready_data", RREADY, 1'b1);
    chk("gnt_once", {if_gnt, ls_gnt}, 2'b00);
  endtask

  // Drives one R beat; beats whose RID matches the owner are expected back on that owner's port.
  task automatic do_r(input logic [3:0] rid, input logic [63:0] d, input logic [1:0] rs, input logic last);
    r_exp_t e;
    logic fwd;
    fwd = (rid == cur_id);
    @(negedge clk);
    RVALID = 1'b1; RID = rid; RDATA = d; RRESP = rs; RLAST = last;
    if (fwd) r_q.push_back('{cur_ls, d, rs});
    #1;
    chk("rready_beat", RREADY, 1'b1);
    chk("if_rvalid", if_rvalid, fwd && !cur_ls);
    chk("ls_rvalid", ls_rvalid, fwd && cur_ls);
    if (r_q.size() > 0 && (if_rvalid || ls_rvalid)) begin
      e = r_q.pop_front();
      chk("rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
      chk("rresp", e.is_ls ? ls_rresp : if_rresp, e.resp);
    end
    r_q.delete();
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0; #1;
    chk("rready_after", RREADY, !(fwd && last));
    chk("arvalid_after", ARVALID, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0; ls_size = '0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    #3;
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_ar_fields", {ARID, ARADDR, ARSIZE, ARBURST, ARPROT}, '0);
    chk("rst_pulses", {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 4'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1; #1;

    // Tie from reset: IF first, then LS with its own size.
    if_req = 1'b1; if_addr = 64'h0000_1000_0000_0040;
    ls_req = 1'b1; ls_addr = 64'h0000_2000_0000_0108; ls_size = 3'b011;
    push_if(if_addr);
    push_ls(ls_addr, ls_size);
    do_ar(0);
    do_r(ID_IF_DEF, 64'h13, RESP_OKAY, 1'b1);
    do_ar(0);
    do_r(ID_LS_DEF, 64'hDEAD_BEEF_0000_0001, RESP_OKAY, 1'b1);

    // Next tie goes to IF again; AR stalled 5 cycles; foreign-RID beat dropped.
    if_req = 1'b1; if_addr = 64'h0000_1000_0000_0080;
    ls_req = 1'b1; ls_addr = 64'h0000_2000_0000_0200; ls_size = 3'b001;
    push_if(if_addr);
    push_ls(ls_addr, ls_size);
    do_ar(5);
    do_r(ID_LS_DEF, 64'hBAD0_BAD0_BAD0_BAD0, RESP_OKAY, 1'b1);
    do_r(ID_IF_DEF, 64'h0123_4567_89AB_CDEF, RESP_OKAY, 1'b1);

    // LS read with SLVERR completes normally.
    do_ar(0);
    do_r(ID_LS_DEF, 64'h55, 2'b10, 1'b1);

    // IF alone.
    if_req = 1'b1; if_addr = 64'h0000_1000_0000_00C4;
    push_if(if_addr);
    do_ar(0);
    do_r(ID_IF_DEF, 64'h13, RESP_OKAY, 1'b1);

    // last grant is IF now, so LS wins this tie; reset hits during its data phase.
    if_req = 1'b1; if_addr = 64'h0000_1000_0000_0100;
    ls_req = 1'b1; ls_addr = 64'h0000_2000_0000_0300; ls_size = 3'b010;
    push_ls(ls_addr, ls_size);
    do_ar(0);
    @(negedge clk);
    RVALID = 1'b1; RID = ID_LS_DEF; RDATA = 64'h77; RLAST = 1'b1; rstn = 1'b0;
    #1;
    chk("rstmid_arvalid", ARVALID, 1'b0);
    chk("rstmid_rready", RREADY, 1'b0);
    chk("rstmid_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
    @(negedge clk);
    RVALID = 1'b0; RLAST = 1'b0; rstn = 1'b1; ls_req = 1'b1;
    #1;
    push_if(if_addr);
    push_ls(ls_addr, ls_size);
    do_ar(0);
    do_r(ID_IF_DEF, 64'h99, RESP_OKAY, 1'b1);
    do_ar(0);
    do_r(ID_LS_DEF, 64'hAA, 2'b11, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
